mem_port_arbiter: RTL and testbench

Arbitrates one single-port synchronous memory between the instruction-fetch stage and the data-memory stage of the MIPS pipeline CPU. The arbiter accepts at most one access at a time, tracks the memory latency with a counter, and returns read data and a completion strobe to the owning requester. The pipeline stalls IF or MEM on the absence of `*_rvalid`. It sits between the pipeline stages and the shared memory, alongside `MipsPipelineCPU`.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch
// stage (IF) and the data-memory stage (DM) of the MIPS pipeline CPU. Only one
// access is outstanding at a time. A counter tracks the fixed memory latency
// and, on the completion cycle, the read data and a one-cycle rvalid strobe
// are returned to whichever requester owns the access. The completion cycle
// is also a grant cycle, so back-to-back requests get one access every
// MEM_LAT cycles.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  cycles from issue to valid mem_rdata (1..15)
//
// Optional feature macro:
//   MEM_ARB_RR_EN  defined   -> round-robin between IF and DM on contention
//                  undefined -> fixed priority, DM wins over IF
//
// Ports:
//   clk, reset                      rising-edge clock, async active-high reset
//   if_req/if_addr                  fetch request (held until if_gnt)
//   if_gnt/if_rdata/if_rvalid       fetch grant, data, completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata   data request (held until dm_gnt)
//   dm_gnt/dm_rdata/dm_rvalid       data grant, read data (0 on writes), pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory issue signals, 0 when idle
//   mem_rdata                       memory read data, valid MEM_LAT after issue
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_rvalid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

   state_t           r_state, w_stateNext;
   owner_t           r_owner, w_ownerNext;
   logic [CNT_W-1:0] r_cnt, w_cntNext;
   logic             r_we, w_weNext;

   logic w_done;
   logic w_eligible;
   logic w_grant;
   logic w_pickDm;

   // The completion cycle is the last cycle of an access; it also opens the
   // next grant window so the memory never sits idle between requests.
   assign w_done     = (r_state == BUSY) && (r_cnt == LAT_C);
   assign w_eligible = ~reset && ((r_state == IDLE) || w_done);
   assign w_grant    = w_eligible && (if_req || dm_req);

`ifdef MEM_ARB_RR_EN
   owner_t r_last;

   // Round-robin: on contention the requester that did not win last time
   // gets the port; with a single requester it simply wins.
   assign w_pickDm = dm_req && (!if_req || (r_last == OWN_IF));

   // Remember the most recent winner for the next contention decision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= OWN_IF;
      end else if (w_grant) begin
         r_last <= w_pickDm ? OWN_DM : OWN_IF;
      end
   end
`else
   // Fixed priority: the older instruction sitting in MEM must progress, so
   // DM wins whenever it is requesting.
   assign w_pickDm = dm_req;
`endif

   assign dm_gnt = w_grant && w_pickDm;
   assign if_gnt = w_grant && !w_pickDm;

   // Memory issue signals are steered from the winner only in a grant cycle
   // and forced to zero otherwise so the memory sees a clean idle bus.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dm_gnt) begin
         mem_en    = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (if_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end
   end

   // Completion strobes and data go only to the owner of the finishing
   // access; a DM write returns zero data alongside its strobe.
   assign if_rvalid = w_done && (r_owner == OWN_IF);
   assign dm_rvalid = w_done && (r_owner == OWN_DM);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign dm_rdata  = (dm_rvalid && !r_we) ? mem_rdata : '0;

   // Next-state logic: a grant always (re)starts the latency counter at 1,
   // even in a completion cycle; otherwise a finishing access drops to IDLE
   // and an outstanding one keeps counting.
   always_comb begin
      w_stateNext = r_state;
      w_ownerNext = r_owner;
      w_cntNext   = r_cnt;
      w_weNext    = r_we;
      if (w_grant) begin
         w_stateNext = BUSY;
         w_ownerNext = w_pickDm ? OWN_DM : OWN_IF;
         w_cntNext   = CNT_W'(1);
         w_weNext    = w_pickDm && dm_we;
      end else if (w_done) begin
         w_stateNext = IDLE;
         w_cntNext   = '0;
         w_weNext    = 1'b0;
      end else if (r_state == BUSY) begin
         w_cntNext   = r_cnt + 1'b1;
      end
   end

   // State registers; reset abandons any outstanding access so no rvalid
   // can follow it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_owner <= OWN_IF;
         r_cnt   <= '0;
         r_we    <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_owner <= w_ownerNext;
         r_cnt   <= w_cntNext;
         r_we    <= w_weNext;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   // Instance A: MEM_LAT = 2
   logic        ifReq = 0, dmReq = 0, dmWe = 0;
   logic [31:0] ifAddr = 0, dmAddr = 0, dmWdata = 0, memRdata = 0;
   logic        ifGnt, ifRvalid, dmGnt, dmRvalid, memEn, memWe;
   logic [31:0] ifRdata, dmRdata, memAddr, memWdata;

   // Instance B: MEM_LAT = 1
   logic        bIfReq = 0, bDmReq = 0, bDmWe = 0;
   logic [31:0] bIfAddr = 0, bDmAddr = 0, bDmWdata = 0, bMemRdata = 0;
   logic        bIfGnt, bIfRvalid, bDmGnt, bDmRvalid, bMemEn, bMemWe;
   logic [31:0] bIfRdata, bDmRdata, bMemAddr, bMemWdata;

   int testsRun = 0;
   int failCount = 0;
   logic rrMode;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dutA (
      .clk(clk), .reset(reset),
      .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt),
      .if_rdata(ifRdata), .if_rvalid(ifRvalid),
      .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
      .dm_gnt(dmGnt), .dm_rdata(dmRdata), .dm_rvalid(dmRvalid),
      .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_rdata(memRdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dutB (
      .clk(clk), .reset(reset),
      .if_req(bIfReq), .if_addr(bIfAddr), .if_gnt(bIfGnt),
      .if_rdata(bIfRdata), .if_rvalid(bIfRvalid),
      .dm_req(bDmReq), .dm_we(bDmWe), .dm_addr(bDmAddr), .dm_wdata(bDmWdata),
      .dm_gnt(bDmGnt), .dm_rdata(bDmRdata), .dm_rvalid(bDmRvalid),
      .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr),
      .mem_wdata(bMemWdata), .mem_rdata(bMemRdata)
   );

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle to mid-cycle before sampling.
   task automatic settle();
      #3;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
`ifdef MEM_ARB_RR_EN
      rrMode = 1'b1;
`else
      rrMode = 1'b0;
`endif
      // Reset held with requests pending: nothing may be granted
      ifReq = 1; ifAddr = 32'h0000_0004; dmReq = 1; dmAddr = 32'h44;
      applyStimulus(); settle();
      checkOutput("rst_if_gnt", ifGnt, 0);
      checkOutput("rst_dm_gnt", dmGnt, 0);
      checkOutput("rst_mem_en", memEn, 0);
      checkOutput("rst_mem_addr", memAddr, 0);
      checkOutput("rst_rvalid", {ifRvalid, dmRvalid}, 0);

      // Single fetch: grant in the first cycle reset is low
      applyStimulus();
      reset = 0; dmReq = 0; dmAddr = 0; settle();
      checkOutput("sf_if_gnt", ifGnt, 1);
      checkOutput("sf_mem_en", memEn, 1);
      checkOutput("sf_mem_addr", memAddr, 32'h4);
      checkOutput("sf_mem_we", memWe, 0);
      applyStimulus();
      ifReq = 0; settle();
      checkOutput("sf_t1_rvalid", ifRvalid, 0);
      checkOutput("sf_t1_mem_en", memEn, 0);
      applyStimulus();
      memRdata = 32'h2008_0005; settle();
      checkOutput("sf_t2_if_rvalid", ifRvalid, 1);
      checkOutput("sf_t2_if_rdata", ifRdata, 32'h2008_0005);
      checkOutput("sf_t2_dm_rvalid", dmRvalid, 0);

      // Contention: DM write wins (also under round-robin, last winner was IF)
      applyStimulus();
      ifReq = 1; ifAddr = 32'h8;
      dmReq = 1; dmWe = 1; dmAddr = 32'h10; dmWdata = 32'hDEAD_BEEF; settle();
      checkOutput("ct_dm_gnt", dmGnt, 1);
      checkOutput("ct_if_gnt", ifGnt, 0);
      checkOutput("ct_mem_we", memWe, 1);
      checkOutput("ct_mem_addr", memAddr, 32'h10);
      checkOutput("ct_mem_wdata", memWdata, 32'hDEAD_BEEF);
      applyStimulus();
      dmReq = 0; dmWe = 0; dmAddr = 0; dmWdata = 0; settle();
      checkOutput("ct_t1_if_gnt", ifGnt, 0);
      checkOutput("ct_t1_mem_addr", memAddr, 0);
      applyStimulus();
      memRdata = 32'h1111_0000; settle();
      checkOutput("ct_t2_dm_rvalid", dmRvalid, 1);
      checkOutput("ct_t2_dm_rdata", dmRdata, 0);
      checkOutput("ct_t2_if_rvalid", ifRvalid, 0);
      checkOutput("ct_t2_if_gnt", ifGnt, 1);
      checkOutput("ct_t2_mem_addr", memAddr, 32'h8);
      checkOutput("ct_t2_mem_we", memWe, 0);

      // Back-to-back fetches: each rvalid coincides with the next grant
      for (int k = 1; k <= 3; k++) begin
         applyStimulus();
         ifAddr = 32'h8 + 32'(4 * k); settle();
         checkOutput("bb_odd_if_gnt", ifGnt, 0);
         checkOutput("bb_odd_if_rvalid", ifRvalid, 0);
         applyStimulus();
         memRdata = 32'h1111_0000 + 32'(k); settle();
         checkOutput("bb_if_rvalid", ifRvalid, 1);
         checkOutput("bb_if_rdata", ifRdata, 32'h1111_0000 + 32'(k));
         checkOutput("bb_if_gnt", ifGnt, 1);
         checkOutput("bb_mem_addr", memAddr, 32'h8 + 32'(4 * k));
      end
      applyStimulus();
      ifReq = 0; settle();
      checkOutput("bb_tail_if_gnt", ifGnt, 0);
      applyStimulus(); settle();
      checkOutput("bb_tail_rvalid", ifRvalid, 1);
      checkOutput("bb_tail_mem_en", memEn, 0);

      // Reset mid-access: DM read abandoned, no rvalid
      applyStimulus();
      dmReq = 1; dmWe = 0; dmAddr = 32'h20; settle();
      checkOutput("rm_dm_gnt", dmGnt, 1);
      checkOutput("rm_mem_we", memWe, 0);
      applyStimulus();
      dmReq = 0; dmAddr = 0; ifReq = 1; ifAddr = 32'h40; reset = 1; settle();
      checkOutput("rm_rst_gnt", {ifGnt, dmGnt}, 0);
      checkOutput("rm_rst_mem_en", memEn, 0);
      checkOutput("rm_rst_mem_addr", memAddr, 0);
      checkOutput("rm_rst_rvalid", {ifRvalid, dmRvalid}, 0);
      applyStimulus(); settle();
      checkOutput("rm_t2_dm_rvalid", dmRvalid, 0);
      applyStimulus();
      reset = 0; settle();
      checkOutput("rm_fresh_if_gnt", ifGnt, 1);
      checkOutput("rm_fresh_mem_addr", memAddr, 32'h40);
      checkOutput("rm_fresh_dm_rvalid", dmRvalid, 0);
      applyStimulus();
      ifReq = 0; settle();
      checkOutput("rm_t1_if_rvalid", ifRvalid, 0);

      // Continuous contention: fixed gives DM,DM; round-robin gives DM,IF,DM
      applyStimulus();
      memRdata = 32'hCAFE_0001;
      ifReq = 1; ifAddr = 32'h50; dmReq = 1; dmAddr = 32'h30; settle();
      checkOutput("cc0_if_rvalid", ifRvalid, 1);
      checkOutput("cc0_dm_gnt", dmGnt, 1);
      checkOutput("cc0_if_gnt", ifGnt, 0);
      applyStimulus(); settle();
      checkOutput("cc1_no_gnt", {ifGnt, dmGnt}, 0);
      applyStimulus();
      memRdata = 32'hCAFE_0002; settle();
      checkOutput("cc2_dm_rvalid", dmRvalid, 1);
      checkOutput("cc2_dm_rdata", dmRdata, 32'hCAFE_0002);
      checkOutput("cc2_dm_gnt", dmGnt, rrMode ? 0 : 1);
      checkOutput("cc2_if_gnt", ifGnt, rrMode ? 1 : 0);
      checkOutput("cc2_mem_addr", memAddr, rrMode ? 32'h50 : 32'h30);
      applyStimulus(); settle();
      applyStimulus(); settle();
      checkOutput("cc4_if_rvalid", ifRvalid, rrMode ? 1 : 0);
      checkOutput("cc4_dm_rvalid", dmRvalid, rrMode ? 0 : 1);
      checkOutput("cc4_dm_gnt", dmGnt, 1);
      checkOutput("cc4_if_gnt", ifGnt, 0);
      applyStimulus();
      ifReq = 0; dmReq = 0; settle();
      applyStimulus(); settle();
      checkOutput("cc6_dm_rvalid", dmRvalid, 1);

      // MEM_LAT = 1: DM read held three cycles, mem_en every cycle
      applyStimulus();
      bDmReq = 1; bDmAddr = 32'h100; bMemRdata = 32'hB000_0000; settle();
      checkOutput("l1_c1_mem_en", bMemEn, 1);
      checkOutput("l1_c1_dm_gnt", bDmGnt, 1);
      checkOutput("l1_c1_dm_rvalid", bDmRvalid, 0);
      for (int k = 1; k <= 2; k++) begin
         applyStimulus();
         bDmAddr = 32'h100 + 32'(4 * k); bMemRdata = 32'hB000_0000 + 32'(k); settle();
         checkOutput("l1_mem_en", bMemEn, 1);
         checkOutput("l1_dm_gnt", bDmGnt, 1);
         checkOutput("l1_mem_addr", bMemAddr, 32'h100 + 32'(4 * k));
         checkOutput("l1_dm_rvalid", bDmRvalid, 1);
         checkOutput("l1_dm_rdata", bDmRdata, 32'hB000_0000 + 32'(k));
      end
      applyStimulus();
      bDmReq = 0; settle();
      checkOutput("l1_c4_mem_en", bMemEn, 0);
      checkOutput("l1_c4_dm_rvalid", bDmRvalid, 1);
      applyStimulus(); settle();
      checkOutput("l1_c5_dm_rvalid", bDmRvalid, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
